wb_cmd_initiator: RTL and testbench
===================================

// Module: wb_cmd_initiator
// PURPOSE
//  Wishbone classic single-cycle initiator: takes read/write commands on a valid/ready
//  port, runs one Wishbone cycle per command toward a slave such as the litex_core
//  register bus, and returns data/status on a valid/ready response port.
//  Gives fabric logic the initiator side of the same bus the AHB-to-FPGA bridge drives.
// PARAMETERS
//  ADR_W      15   word-address width (wb_adr); byte address = {wb_adr,2'b00}
//  TIMEOUT    255  max cycles waiting for ack/err before abort; 0 = timeout disabled
//  TO_W       8    timeout counter width; must satisfy TIMEOUT < 2**TO_W
// PORTS
//  WB_CLK       in   1      bus clock, all logic on posedge
//  WB_RST_N     in   1      asynchronous, active-low reset
//  cmd_valid    in   1      command present
//  cmd_ready    out  1      command accepted when valid&ready
//  cmd_we       in   1      1=write, 0=read
//  cmd_adr      in   ADR_W  word address
//  cmd_dat      in   32     write data
//  cmd_sel      in   4      byte enables
//  rsp_valid    out  1      response present
//  rsp_ready    in   1      response consumed when valid&ready
//  rsp_dat      out  32     read data (0 for writes, err, timeout)
//  rsp_err      out  1      slave signalled wb_err
//  rsp_timeout  out  1      cycle aborted by timeout
//  wb_adr       out  ADR_W  / wb_dat_w out 32 / wb_sel out 4 / wb_we out 1
//  wb_cyc       out  1      / wb_stb out 1   (always equal)
//  wb_cti       out  3      constant 3'b000 ; wb_bte out 2 constant 2'b00
//  wb_dat_r     in   32     / wb_ack in 1 / wb_err in 1
//  txn_count    out  16     completed transactions (ok+err+timeout), wraps 0xFFFF->0
// BEHAVIOUR
//  Reset (async, WB_RST_N=0): FSM=IDLE; wb_cyc/wb_stb/wb_we=0, wb_adr/dat_w/sel=0;
//   rsp_valid=0, rsp_dat=0, rsp_err=0, rsp_timeout=0, txn_count=0, timer=0.
//   Reset mid-cycle drops wb_cyc/wb_stb immediately; in-flight command is lost.
//  FSM IDLE -> BUS -> RESP -> IDLE; all outputs registered; cmd_ready = (state==IDLE).
//  IDLE: on cmd_valid: latch we/adr/dat/sel onto wb_* outputs, wb_cyc=wb_stb=1, timer=0,
//   go BUS. wb_dat_w driven 0 for reads.
//  BUS: wb_* held stable. Each cycle sample wb_ack/wb_err:
//   err=1 (wins over simultaneous ack): rsp_err=1, rsp_dat=0.
//   ack=1, err=0: rsp_dat = we ? 0 : wb_dat_r, rsp_err=0.
//   neither, TIMEOUT!=0 and timer==TIMEOUT-1: rsp_timeout=1, rsp_dat=0.
//   neither otherwise: timer+=1, stay BUS.
//   On any exit: wb_cyc=wb_stb=wb_we=0 next cycle, rsp_valid=1, txn_count+=1, go RESP.
//  RESP: rsp_* held stable while rsp_valid&&!rsp_ready; on rsp_ready: rsp_valid=0,
//   rsp_err/rsp_timeout cleared, go IDLE. ack/err arriving outside BUS are ignored.
//  Latency: accept at edge N -> wb_stb high after N; ack sampled at edge M (M>=N+1)
//   -> rsp_valid high after M. Minimum 1 idle cycle between successive wb cycles.
//  Timeout: wb_stb asserted exactly TIMEOUT cycles before abort with no ack.
// TESTING
//  1 Write cmd adr=0x0040 dat=0xA5A5_1234 sel=0xF, slave acks 2nd cycle of stb ->
//    wb_we=1, wb_adr=0x0040 seen; rsp_valid with rsp_err=0, rsp_dat=0, txn_count=1.
//  2 Read adr=0x0001, slave acks first cycle with dat_r=0xDEAD_BEEF ->
//    rsp_dat=0xDEAD_BEEF one edge after ack; wb_cyc low same edge.
//  3 Read, slave never acks, TIMEOUT=255 -> stb high 255 cycles, rsp_timeout=1,
//    rsp_dat=0; next command accepted normally afterwards.
//  4 Slave asserts ack and err same cycle -> rsp_err=1, rsp_dat=0.
//  5 Hold rsp_ready=0 10 cycles with cmd_valid=1 -> cmd_ready=0, no new wb_cyc,
//    rsp fields stable; release -> next cmd accepted cycle after handshake.
//  6 Assert WB_RST_N=0 mid-BUS -> wb_cyc/wb_stb low without clock edge; all outputs
//    at reset values; txn_count wrap from 0xFFFF to 0 checked by preload/long run.

Source files
------------

// File: rtl/wb_cmd_initiator.sv
// Wishbone classic single-cycle initiator: one bus cycle per valid/ready command,
// with the result returned on a valid/ready response port.
module wb_cmd_initiator #(
    parameter int unsigned ADR_W   = 15,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 8
) (
    input  logic             WB_CLK,
    input  logic             WB_RST_N,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_we,
    input  logic [ADR_W-1:0] cmd_adr,
    input  logic [31:0]      cmd_dat,
    input  logic [3:0]       cmd_sel,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_dat,
    output logic             rsp_err,
    output logic             rsp_timeout,
    output logic [ADR_W-1:0] wb_adr,
    output logic [31:0]      wb_dat_w,
    output logic [3:0]       wb_sel,
    output logic             wb_we,
    output logic             wb_cyc,
    output logic             wb_stb,
    output logic [2:0]       wb_cti,
    output logic [1:0]       wb_bte,
    input  logic [31:0]      wb_dat_r,
    input  logic             wb_ack,
    input  logic             wb_err,
    output logic [15:0]      txn_count
);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

    state_t          state;
    logic [TO_W-1:0] timer;
    logic            timeout_hit;

    assign cmd_ready   = (state == IDLE);
    assign wb_stb      = wb_cyc;
    assign wb_cti      = 3'b000;
    assign wb_bte      = 2'b00;
    assign timeout_hit = (TIMEOUT != 0) && (timer == TO_LAST);

    always_ff @(posedge WB_CLK or negedge WB_RST_N) begin
        if (!WB_RST_N) begin
            state       <= IDLE;
            timer       <= '0;
            wb_cyc      <= 1'b0;
            wb_we       <= 1'b0;
            wb_adr      <= '0;
            wb_dat_w    <= '0;
            wb_sel      <= '0;
            rsp_valid   <= 1'b0;
            rsp_dat     <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            txn_count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        wb_cyc   <= 1'b1;
                        wb_we    <= cmd_we;
                        wb_adr   <= cmd_adr;
                        wb_dat_w <= cmd_we ? cmd_dat : '0;
                        wb_sel   <= cmd_sel;
                        timer    <= '0;
                        state    <= BUS;
                    end
                end
                BUS: begin
                    if (wb_err || wb_ack || timeout_hit) begin
                        // err takes priority over a simultaneous ack; only clean read acks carry data
                        rsp_err     <= wb_err;
                        rsp_timeout <= !wb_err && !wb_ack;
                        rsp_dat     <= (wb_ack && !wb_err && !wb_we) ? wb_dat_r : '0;
                        rsp_valid   <= 1'b1;
                        wb_cyc      <= 1'b0;
                        wb_we       <= 1'b0;
                        txn_count   <= txn_count + 16'd1;
                        state       <= RESP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid   <= 1'b0;
                        rsp_err     <= 1'b0;
                        rsp_timeout <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_cmd_initiator.sv
// Directed bench for wb_cmd_initiator: write/read/timeout/err/back-pressure/reset/wrap.
module tb_wb_cmd_initiator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [14:0] cmd_adr;
    logic [31:0] cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [31:0] rsp_dat;
    logic [14:0] wb_adr;
    logic [31:0] wb_dat_w, wb_dat_r;
    logic [3:0]  wb_sel;
    logic        wb_we, wb_cyc, wb_stb, wb_ack, wb_err;
    logic [2:0]  wb_cti;
    logic [1:0]  wb_bte;
    logic [15:0] txn_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wb_cmd_initiator #(.ADR_W(15), .TIMEOUT(255), .TO_W(8)) dut (
        .WB_CLK(clk), .WB_RST_N(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .wb_adr(wb_adr), .wb_dat_w(wb_dat_w), .wb_sel(wb_sel), .wb_we(wb_we),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_cti(wb_cti), .wb_bte(wb_bte),
        .wb_dat_r(wb_dat_r), .wb_ack(wb_ack), .wb_err(wb_err),
        .txn_count(txn_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
        rsp_ready = 1'b0; wb_dat_r = '0; wb_ack = 1'b0; wb_err = 1'b0;

        // reset values
        #2;
        chk("rst_cyc", 32'(wb_cyc), 32'd0);
        chk("rst_stb", 32'(wb_stb), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_txn", 32'(txn_count), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("cti", 32'(wb_cti), 32'd0);
        chk("bte", 32'(wb_bte), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // 1: write, ack on second stb cycle
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 15'h0040; cmd_dat = 32'hA5A5_1234; cmd_sel = 4'hF;
        tick();
        cmd_valid = 1'b0;
        chk("w_cyc", 32'(wb_cyc), 32'd1);
        chk("w_stb", 32'(wb_stb), 32'd1);
        chk("w_we", 32'(wb_we), 32'd1);
        chk("w_adr", 32'(wb_adr), 32'h40);
        chk("w_dat", wb_dat_w, 32'hA5A5_1234);
        chk("w_sel", 32'(wb_sel), 32'hF);
        chk("w_cmd_ready", 32'(cmd_ready), 32'd0);
        tick();
        chk("w_cyc_hold", 32'(wb_cyc), 32'd1);
        chk("w_rsp_early", 32'(rsp_valid), 32'd0);
        wb_ack = 1'b1; wb_dat_r = 32'h1111_2222;
        tick();
        wb_ack = 1'b0;
        chk("w_cyc_drop", 32'(wb_cyc), 32'd0);
        chk("w_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("w_rsp_err", 32'(rsp_err), 32'd0);
        chk("w_rsp_dat", rsp_dat, 32'd0);
        chk("w_txn", 32'(txn_count), 32'd1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("w_rsp_clear", 32'(rsp_valid), 32'd0);
        chk("w_ready_back", 32'(cmd_ready), 32'd1);

        // 2: read, ack on first stb cycle
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 15'h0001; cmd_dat = 32'hFFFF_FFFF; cmd_sel = 4'h3;
        tick();
        cmd_valid = 1'b0;
        chk("r_we", 32'(wb_we), 32'd0);
        chk("r_dat_w_zero", wb_dat_w, 32'd0);
        chk("r_adr", 32'(wb_adr), 32'h1);
        wb_ack = 1'b1; wb_dat_r = 32'hDEAD_BEEF;
        tick();
        wb_ack = 1'b0;
        chk("r_rsp_dat", rsp_dat, 32'hDEAD_BEEF);
        chk("r_cyc_drop", 32'(wb_cyc), 32'd0);
        chk("r_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("r_txn", 32'(txn_count), 32'd2);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // 3: no ack -> timeout after exactly 255 stb cycles
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 15'h0002; wb_dat_r = 32'h5555_AAAA;
        tick();
        cmd_valid = 1'b0;
        n = 0;
        while (wb_stb === 1'b1 && n < 1000) begin
            n++;
            tick();
        end
        chk("to_stb_cycles", 32'(n), 32'd255);
        chk("to_flag", 32'(rsp_timeout), 32'd1);
        chk("to_err", 32'(rsp_err), 32'd0);
        chk("to_dat", rsp_dat, 32'd0);
        chk("to_txn", 32'(txn_count), 32'd3);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("to_flag_clear", 32'(rsp_timeout), 32'd0);

        // 4: ack and err together -> err wins
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 15'h0003;
        tick();
        cmd_valid = 1'b0;
        chk("e_cyc", 32'(wb_cyc), 32'd1);
        wb_ack = 1'b1; wb_err = 1'b1; wb_dat_r = 32'hCAFE_F00D;
        tick();
        wb_ack = 1'b0; wb_err = 1'b0;
        chk("e_err", 32'(rsp_err), 32'd1);
        chk("e_dat", rsp_dat, 32'd0);
        chk("e_timeout", 32'(rsp_timeout), 32'd0);
        chk("e_txn", 32'(txn_count), 32'd4);

        // 5: response back-pressure with a pending command; stray acks ignored
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 15'h0005; cmd_dat = 32'h0BAD_F00D; cmd_sel = 4'h1;
        for (int i = 0; i < 10; i++) begin
            wb_ack = i[0];
            tick();
            chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("bp_cyc", 32'(wb_cyc), 32'd0);
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_err", 32'(rsp_err), 32'd1);
            chk("bp_rsp_dat", rsp_dat, 32'd0);
        end
        wb_ack = 1'b0;
        chk("bp_txn", 32'(txn_count), 32'd4);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("bp_release_ready", 32'(cmd_ready), 32'd1);
        chk("bp_release_cyc", 32'(wb_cyc), 32'd0);
        tick();
        cmd_valid = 1'b0;
        chk("bp_accept_cyc", 32'(wb_cyc), 32'd1);
        chk("bp_accept_adr", 32'(wb_adr), 32'h5);
        wb_ack = 1'b1;
        tick();
        wb_ack = 1'b0;
        chk("bp_txn5", 32'(txn_count), 32'd5);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // txn_count wrap from 0xFFFF
        force dut.txn_count = 16'hFFFF;
        #1;
        release dut.txn_count;
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 15'h0007;
        tick();
        cmd_valid = 1'b0;
        wb_ack = 1'b1;
        tick();
        wb_ack = 1'b0;
        chk("wrap_txn", 32'(txn_count), 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // 6: asynchronous reset in the middle of a bus cycle
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 15'h7FFF; cmd_dat = 32'h1234_5678; cmd_sel = 4'hC;
        tick();
        cmd_valid = 1'b0;
        chk("ar_cyc_before", 32'(wb_cyc), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_cyc", 32'(wb_cyc), 32'd0);
        chk("ar_stb", 32'(wb_stb), 32'd0);
        chk("ar_we", 32'(wb_we), 32'd0);
        chk("ar_adr", 32'(wb_adr), 32'd0);
        chk("ar_dat_w", wb_dat_w, 32'd0);
        chk("ar_sel", 32'(wb_sel), 32'd0);
        chk("ar_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("ar_txn", 32'(txn_count), 32'd0);
        chk("ar_cmd_ready", 32'(cmd_ready), 32'd1);
        tick();
        rst_n = 1'b1;
        tick();

        // recovery after reset
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 15'h0010;
        tick();
        cmd_valid = 1'b0;
        wb_ack = 1'b1; wb_dat_r = 32'h0F0F_0F0F;
        tick();
        wb_ack = 1'b0;
        chk("rec_dat", rsp_dat, 32'h0F0F_0F0F);
        chk("rec_txn", 32'(txn_count), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
